// File: rtl/inst_fetch_unit.sv
// Instruction fetch front end: fetch PC register, combinational instruction memory read,
// and an in-order prefetch FIFO that hands {pc, inst} to decode with valid/ready.
module inst_fetch_unit #(
  parameter int          ADDR_W   = 6,
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic                      clk,
  input  logic                      rst,
  output logic [ADDR_W-1:0]         imem_offset,
  input  logic [31:0]               imem_data,
  input  logic                      redirect_valid,
  input  logic [31:0]               redirect_pc,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [31:0]               out_inst,
  output logic [31:0]               out_pc,
  output logic [$clog2(DEPTH):0]    fifo_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  logic [31:0]      fetch_pc_q, fetch_pc_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [31:0]      fifo_pc_q   [DEPTH];
  logic [31:0]      fifo_pc_d   [DEPTH];
  logic [31:0]      fifo_inst_q [DEPTH];
  logic [31:0]      fifo_inst_d [DEPTH];

  logic pop;
  logic push;

  // Offset comes only from the PC register, so there is no path from ready/redirect.
  assign imem_offset = fetch_pc_q[ADDR_W+1:2];

  assign out_valid  = (count_q != '0);
  assign out_pc     = out_valid ? fifo_pc_q[rd_ptr_q]   : 32'h0;
  assign out_inst   = out_valid ? fifo_inst_q[rd_ptr_q] : NOP_INST;
  assign fifo_count = count_q;

  assign pop  = out_valid & out_ready;
  assign push = !redirect_valid & ((count_q < CNT_W'(DEPTH)) | pop);

  always_comb begin
    fetch_pc_d  = fetch_pc_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    fifo_pc_d   = fifo_pc_q;
    fifo_inst_d = fifo_inst_q;

    // A redirect flushes everything, including a pop offered in the same cycle.
    if (redirect_valid) begin
      fetch_pc_d = redirect_pc & 32'hFFFF_FFFC;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
    end else begin
      if (push) begin
        fifo_pc_d[wr_ptr_q]   = fetch_pc_q;
        fifo_inst_d[wr_ptr_q] = imem_data;
        wr_ptr_d              = wr_ptr_q + 1'b1;
        fetch_pc_d            = fetch_pc_q + 32'd4;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      if (push && !pop) begin
        count_d = count_q + 1'b1;
      end else if (pop && !push) begin
        count_d = count_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q  <= RESET_PC;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      fifo_pc_q   <= '{default: '0};
      fifo_inst_q <= '{default: '0};
    end else begin
      fetch_pc_q  <= fetch_pc_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      fifo_pc_q   <= fifo_pc_d;
      fifo_inst_q <= fifo_inst_d;
    end
  end

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Self-checking bench for inst_fetch_unit: queue-based reference model compared every
// cycle, plus directed scenarios with hand-computed literal expectations.
module tb_inst_fetch_unit;

  logic        clk;
  logic        rst;
  logic [5:0]  imem_offset;
  logic [31:0] imem_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic [31:0] out_pc;
  logic [2:0]  fifo_count;

  logic [31:0] mem [64];

  int compared   = 0;
  int mismatched = 0;
  bit checkEn    = 0;

  // Reference model: fetch PC plus a queue of {pc, inst} pairs, capacity 4.
  logic [31:0] modelPc = 32'h0;
  logic [31:0] modelPcQ [$];
  logic [31:0] modelInstQ [$];

  inst_fetch_unit #(
    .ADDR_W   (6),
    .DEPTH    (4),
    .RESET_PC (32'h0)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_offset    (imem_offset),
    .imem_data      (imem_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_inst       (out_inst),
    .out_pc         (out_pc),
    .fifo_count     (fifo_count)
  );

  assign imem_data = mem[imem_offset];

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  // Model update on each rising edge, using only bench-side state and the driven inputs.
  always @(posedge clk) begin
    bit doPop;
    bit doPush;
    if (rst) begin
      modelPc = 32'h0;
      modelPcQ.delete();
      modelInstQ.delete();
    end else if (redirect_valid) begin
      modelPc = {redirect_pc[31:2], 2'b00};
      modelPcQ.delete();
      modelInstQ.delete();
    end else begin
      doPop  = (modelPcQ.size() > 0) && out_ready;
      doPush = (modelPcQ.size() < 4) || doPop;
      if (doPop) begin
        void'(modelPcQ.pop_front());
        void'(modelInstQ.pop_front());
      end
      if (doPush) begin
        modelPcQ.push_back(modelPc);
        modelInstQ.push_back(mem[modelPc[7:2]]);
        modelPc = modelPc + 32'd4;
      end
    end
  end

  // Every-cycle comparison against the model, sampled away from the active edge.
  always @(negedge clk) begin
    if (checkEn) begin
      bit v;
      v = (modelPcQ.size() != 0);
      checkOutput("m_valid",  32'(out_valid),  32'(v));
      checkOutput("m_pc",     out_pc,          v ? modelPcQ[0] : 32'h0);
      checkOutput("m_inst",   out_inst,        v ? modelInstQ[0] : 32'h13);
      checkOutput("m_count",  32'(fifo_count), 32'(modelPcQ.size()));
      checkOutput("m_offset", 32'(imem_offset), 32'(modelPc[7:2]));
    end
  end

  // Drive inputs for the coming edge, then advance to just after it.
  task automatic applyStimulus(input logic r, input logic rv, input logic [31:0] rpc,
                               input logic rdy);
    rst            = r;
    redirect_valid = rv;
    redirect_pc    = rpc;
    out_ready      = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic checkHead(input string name, input logic v, input logic [31:0] pc,
                           input logic [31:0] inst, input logic [2:0] cnt);
    checkOutput({name, "_valid"}, 32'(out_valid),  32'(v));
    checkOutput({name, "_pc"},    out_pc,          pc);
    checkOutput({name, "_inst"},  out_inst,        inst);
    checkOutput({name, "_count"}, 32'(fifo_count), 32'(cnt));
  endtask

  initial begin
    logic [3:0] readyPattern;
    for (int i = 0; i < 64; i++) mem[i] = 32'h1000 + i;
    rst = 1; redirect_valid = 0; redirect_pc = 0; out_ready = 1;

    // Scenario 1: streaming with out_ready held high
    applyStimulus(1, 0, 0, 1);
    checkEn = 1;
    checkHead("t1_reset", 0, 32'h0, 32'h13, 3'd0);
    checkOutput("t1_reset_offset", 32'(imem_offset), 32'd0);
    applyStimulus(0, 0, 0, 1);
    checkHead("t1_first", 1, 32'h0, 32'h1000, 3'd1);
    for (int k = 1; k <= 3; k++) begin
      applyStimulus(0, 0, 0, 1);
      checkHead("t1_stream", 1, 32'(4 * k), 32'h1000 + 32'(k), 3'd1);
    end

    // Scenario 2: decode stalled, FIFO fills, then drains in order with no gap
    applyStimulus(1, 0, 0, 0);
    for (int k = 1; k <= 5; k++) begin
      applyStimulus(0, 0, 0, 0);
      checkHead("t2_fill", 1, 32'h0, 32'h1000, (k > 4) ? 3'd4 : 3'(k));
    end
    checkOutput("t2_offset_held", 32'(imem_offset), 32'd4);
    for (int k = 1; k <= 4; k++) begin
      applyStimulus(0, 0, 0, 1);
      checkHead("t2_drain", 1, 32'(4 * k), 32'h1000 + 32'(k), 3'd4);
    end

    // Scenario 3: redirect from a full FIFO with unaligned target
    applyStimulus(0, 1, 32'h43, 0);
    checkHead("t3_flush", 0, 32'h0, 32'h13, 3'd0);
    checkOutput("t3_offset", 32'(imem_offset), 32'd16);
    applyStimulus(0, 0, 0, 0);
    checkHead("t3_target", 1, 32'h40, 32'h1010, 3'd1);

    // Scenario 4: offset wrap at the top of the 64-word memory
    applyStimulus(0, 1, 32'hFC, 1);
    checkOutput("t4_offset", 32'(imem_offset), 32'd63);
    applyStimulus(0, 0, 0, 1);
    checkHead("t4_fc", 1, 32'hFC, 32'h103F, 3'd1);
    applyStimulus(0, 0, 0, 1);
    checkHead("t4_100", 1, 32'h100, 32'h1000, 3'd1);
    checkOutput("t4_offset_wrap", 32'(imem_offset), 32'd1);

    // Scenario 5: redirect and pop together with three entries queued
    applyStimulus(1, 0, 0, 0);
    for (int k = 0; k < 3; k++) applyStimulus(0, 0, 0, 0);
    checkHead("t5_three", 1, 32'h0, 32'h1000, 3'd3);
    applyStimulus(0, 1, 32'h80, 1);
    checkHead("t5_flush", 0, 32'h0, 32'h13, 3'd0);
    applyStimulus(0, 0, 0, 1);
    checkHead("t5_target", 1, 32'h80, 32'h1020, 3'd1);
    applyStimulus(0, 0, 0, 1);
    checkHead("t5_next", 1, 32'h84, 32'h1021, 3'd1);

    // Irregular ready pattern to exercise simultaneous push/pop at varied occupancy
    readyPattern = 4'b1010;
    for (int k = 0; k < 16; k++) applyStimulus(0, 0, 0, readyPattern[k % 4]);
    readyPattern = 4'b0011;
    for (int k = 0; k < 16; k++) applyStimulus(0, 0, 0, readyPattern[k % 4]);

    // Scenario 6: reset overrides a concurrent redirect with a full FIFO
    for (int k = 0; k < 5; k++) applyStimulus(0, 0, 0, 0);
    checkOutput("t6_full", 32'(fifo_count), 32'd4);
    applyStimulus(1, 1, 32'h40, 1);
    checkHead("t6_reset", 0, 32'h0, 32'h13, 3'd0);
    checkOutput("t6_offset", 32'(imem_offset), 32'd0);
    applyStimulus(0, 0, 0, 0);
    checkHead("t6_restart", 1, 32'h0, 32'h1000, 3'd1);

    applyStimulus(0, 0, 0, 0);
    checkEn = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
